// File: rtl/lut_array_pkg.sv
// Shared constants, config-write record and table offset helper for the LUT neuron array.
// Optional readback port is enabled by LUT_READBACK_EN (see lut_neuron_array_prog).
package lut_array_pkg;
   localparam int N_NEURONS_DEF = 8;
   localparam int FAN_IN_DEF    = 6;
   localparam int OUT_W_DEF     = 1;

   typedef struct packed {
      logic [7:0] nid;
      logic [7:0] addr;
      logic [7:0] data;
   } cfg_wr_t;

   // Flat bit offset of entry (nid, addr) when all tables are laid end to end.
   function automatic int unsigned tbl_off(int unsigned nid, int unsigned addr,
                                           int unsigned fan_in, int unsigned out_w);
      return ((nid << fan_in) + addr) * out_w;
   endfunction
endpackage

// File: rtl/lut_neuron_array_prog_if.sv
// Datapath handshake and config bus of the LUT neuron array.
// Readback signals exist only when LUT_READBACK_EN is defined.
interface lut_neuron_array_prog_if
   import lut_array_pkg::*;
#(
   parameter int N_NEURONS = N_NEURONS_DEF,
   parameter int FAN_IN    = FAN_IN_DEF,
   parameter int OUT_W     = OUT_W_DEF,
   parameter int NID_W     = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
);
   logic                        in_valid;
   logic                        in_ready;
   logic [N_NEURONS*FAN_IN-1:0] in_data;
   logic                        out_valid;
   logic                        out_ready;
   logic [N_NEURONS*OUT_W-1:0]  out_data;
   logic                        cfg_we;
   logic [NID_W-1:0]            cfg_nid;
   logic [FAN_IN-1:0]           cfg_addr;
   logic [OUT_W-1:0]            cfg_data;
   logic                        cfg_err;
`ifdef LUT_READBACK_EN
   logic                        cfg_re;
   logic [OUT_W-1:0]            cfg_rdata;
   logic                        cfg_rvalid;
`endif

   modport master (
      output in_valid, in_data, out_ready, cfg_we, cfg_nid, cfg_addr, cfg_data,
`ifdef LUT_READBACK_EN
      output cfg_re, input cfg_rdata, cfg_rvalid,
`endif
      input  in_ready, out_valid, out_data, cfg_err
   );

   modport slave (
      input  in_valid, in_data, out_ready, cfg_we, cfg_nid, cfg_addr, cfg_data,
`ifdef LUT_READBACK_EN
      input  cfg_re, output cfg_rdata, cfg_rvalid,
`endif
      output in_ready, out_valid, out_data, cfg_err
   );
endinterface

// File: rtl/lut_neuron_array_prog_neuron.sv
// One programmable LUT neuron: flop-based truth table, write decode, combinational lookup.
// With LUT_READBACK_EN the entry at the config address is also exposed.
module lut_neuron_prog
   import lut_array_pkg::*;
#(
   parameter int FAN_IN = FAN_IN_DEF,
   parameter int OUT_W  = OUT_W_DEF
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we_i,
   input  logic [FAN_IN-1:0] addr_i,
   input  logic [OUT_W-1:0]  data_i,
   input  logic [FAN_IN-1:0] lk_addr_i,
`ifdef LUT_READBACK_EN
   output logic [OUT_W-1:0]  rd_data_o,
`endif
   output logic [OUT_W-1:0]  lk_data_o
);
   localparam int DEPTH = 1 << FAN_IN;

   logic [DEPTH-1:0][OUT_W-1:0] tbl_d, tbl_q;

   always_comb begin
      tbl_d = tbl_q;
      if (we_i) tbl_d[addr_i] = data_i;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) tbl_q <= '0;
      else        tbl_q <= tbl_d;
   end

   assign lk_data_o = tbl_q[lk_addr_i];
`ifdef LUT_READBACK_EN
   assign rd_data_o = tbl_q[addr_i];
`endif
endmodule

// File: rtl/lut_neuron_array_prog.sv
// Runtime-programmable LUT neuron array: one registered lookup stage with valid/ready.
// Define LUT_READBACK_EN to add the cfg_re/cfg_rdata/cfg_rvalid table readback port.
module lut_neuron_array_prog
   import lut_array_pkg::*;
#(
   parameter int N_NEURONS = N_NEURONS_DEF,
   parameter int FAN_IN    = FAN_IN_DEF,
   parameter int OUT_W     = OUT_W_DEF,
   parameter int NID_W     = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
)(
   input  logic                   clk,
   input  logic                   rst_n,
   lut_neuron_array_prog_if.slave bus
);
   logic [N_NEURONS-1:0]            we_n;
   logic [N_NEURONS-1:0][OUT_W-1:0] lk_data;
   logic [N_NEURONS*OUT_W-1:0]      out_data_d, out_data_q;
   logic                            out_valid_d, out_valid_q;
   logic                            cfg_err_d, cfg_err_q;
   logic                            nid_oor, accept;

   assign nid_oor = (32'(bus.cfg_nid) >= 32'(N_NEURONS));

   // Writes take priority over lookups so a lookup never sees a half-written table.
   assign bus.in_ready = !bus.cfg_we && (!out_valid_q || bus.out_ready);
   assign accept       = bus.in_valid && bus.in_ready;

`ifdef LUT_READBACK_EN
   logic [N_NEURONS-1:0][OUT_W-1:0] rd_data;
   logic [OUT_W-1:0]                cfg_rdata_d, cfg_rdata_q;
   logic                            cfg_rvalid_d, cfg_rvalid_q;
`endif

   for (genvar n = 0; n < N_NEURONS; n++) begin : g_neuron
      assign we_n[n] = bus.cfg_we && (bus.cfg_nid == NID_W'(n));
      lut_neuron_prog #(.FAN_IN(FAN_IN), .OUT_W(OUT_W)) u_neuron (
         .clk       (clk),
         .rst_n     (rst_n),
         .we_i      (we_n[n]),
         .addr_i    (bus.cfg_addr),
         .data_i    (bus.cfg_data),
         .lk_addr_i (bus.in_data[n*FAN_IN +: FAN_IN]),
`ifdef LUT_READBACK_EN
         .rd_data_o (rd_data[n]),
`endif
         .lk_data_o (lk_data[n])
      );
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      cfg_err_d   = cfg_err_q | (bus.cfg_we && nid_oor);
      if (accept) begin
         out_valid_d = 1'b1;
         out_data_d  = lk_data;
      end else if (bus.out_ready) begin
         out_valid_d = 1'b0;
      end
`ifdef LUT_READBACK_EN
      cfg_rvalid_d = bus.cfg_re && !bus.cfg_we;
      cfg_rdata_d  = cfg_rdata_q;
      if (cfg_rvalid_d) begin
         cfg_rdata_d = '0;
         cfg_err_d   = cfg_err_d | nid_oor;
         for (int n = 0; n < N_NEURONS; n++)
            if (bus.cfg_nid == NID_W'(n)) cfg_rdata_d = rd_data[n];
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         cfg_err_q   <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         cfg_err_q   <= cfg_err_d;
      end
   end

`ifdef LUT_READBACK_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cfg_rvalid_q <= 1'b0;
         cfg_rdata_q  <= '0;
      end else begin
         cfg_rvalid_q <= cfg_rvalid_d;
         cfg_rdata_q  <= cfg_rdata_d;
      end
   end
   assign bus.cfg_rvalid = cfg_rvalid_q;
   assign bus.cfg_rdata  = cfg_rdata_q;
`endif

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.cfg_err   = cfg_err_q;
endmodule

// File: tb/tb_lut_neuron_array_prog.sv
// Scoreboard bench for lut_neuron_array_prog: directed scenarios then random traffic.
module tb_lut_neuron_array_prog;
   import lut_array_pkg::*;

   localparam int N     = 8;
   localparam int FI    = 6;
   localparam int OW    = 1;
   localparam int NW    = 4;
   localparam int DEPTH = 1 << FI;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   lut_neuron_array_prog_if #(.N_NEURONS(N), .FAN_IN(FI), .OUT_W(OW), .NID_W(NW)) bus ();
   lut_neuron_array_prog #(.N_NEURONS(N), .FAN_IN(FI), .OUT_W(OW), .NID_W(NW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Reference: every table as one flat bit vector, plus expected-output queue.
   logic [N*DEPTH*OW-1:0] mtab;
   logic [N*OW-1:0]       expq[$];
   bit                    mvalid, merr;
   int                    checks, errors;

   function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endfunction

   function automatic logic [N*OW-1:0] model_eval(logic [N*FI-1:0] d);
      logic [N*OW-1:0] r;
      for (int n = 0; n < N; n++)
         r[n*OW +: OW] = mtab[tbl_off(n, d[n*FI +: FI], FI, OW) +: OW];
      return r;
   endfunction

   function automatic logic [N*FI-1:0] rep(logic [FI-1:0] v);
      return {N{v}};
   endfunction

   task automatic tick();
      bit exp_rdy, acc;
      @(negedge clk);
      exp_rdy = !bus.cfg_we && (!mvalid || bus.out_ready);
      if (rst_n) begin
         chk("in_ready", bus.in_ready, exp_rdy);
         chk("out_valid", bus.out_valid, mvalid);
         chk("cfg_err", bus.cfg_err, merr);
         acc = bus.in_valid && exp_rdy;
         if (acc) expq.push_back(model_eval(bus.in_data));
         if (bus.cfg_we) begin
            if (bus.cfg_nid < N) mtab[tbl_off(bus.cfg_nid, bus.cfg_addr, FI, OW) +: OW] = bus.cfg_data;
            else merr = 1'b1;
         end
         if (acc) mvalid = 1'b1;
         else if (bus.out_ready) mvalid = 1'b0;
      end else begin
         mtab = '0;
         expq.delete();
         mvalid = 1'b0;
         merr = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive(bit iv, logic [N*FI-1:0] d, bit ordy, bit we = 1'b0,
                        logic [NW-1:0] nid = '0, logic [FI-1:0] a = '0, logic [OW-1:0] dat = '0);
      bus.in_valid  = iv;
      bus.in_data   = d;
      bus.out_ready = ordy;
      bus.cfg_we    = we;
      bus.cfg_nid   = nid;
      bus.cfg_addr  = a;
      bus.cfg_data  = dat;
      tick();
   endtask

   // Monitor: held results must match the queue head; a handshake retires it.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && bus.out_valid === 1'b1) begin
         if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL out_unexpected: got %0h expected none", bus.out_data);
         end else begin
            chk(bus.out_ready ? "out_data" : "out_hold", bus.out_data, expq[0]);
            if (bus.out_ready) void'(expq.pop_front());
         end
      end
   end

   initial begin
      logic [N*FI-1:0] d;
      logic [63:0]     r64;
      mtab = '0;
      bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
      bus.cfg_we = 1'b0; bus.cfg_nid = '0; bus.cfg_addr = '0; bus.cfg_data = '0;
`ifdef LUT_READBACK_EN
      bus.cfg_re = 1'b0;
`endif
      // Reset, then lookup against all-zero tables
      drive(1'b0, '0, 1'b0);
      drive(1'b0, '0, 1'b0);
      rst_n = 1'b1;
      chk("rst_out_data", bus.out_data, '0);
      drive(1'b1, rep(6'b101010), 1'b1);
      drive(1'b0, '0, 1'b1);
      drive(1'b0, '0, 1'b1);

      // Program neuron 0 entry 0 and neuron 7 entry 63
      drive(1'b0, '0, 1'b1, 1'b1, 4'd0, 6'd0, 1'b1);
      drive(1'b0, '0, 1'b1, 1'b1, 4'd7, 6'd63, 1'b1);
      drive(1'b1, {6'h3f, {6{6'h01}}, 6'h00}, 1'b1);
      drive(1'b0, '0, 1'b1);

      // Backpressure: hold for 5 cycles, then 4 back-to-back results
      drive(1'b1, {6'h3f, {6{6'h01}}, 6'h00}, 1'b0);
      for (int i = 0; i < 5; i++) begin
         r64 = {$urandom(), $urandom()};
         drive(1'b1, r64[N*FI-1:0], 1'b0);
      end
      drive(1'b1, rep(6'h00), 1'b1);
      drive(1'b1, rep(6'h3f), 1'b1);
      drive(1'b1, {6'h3f, {6{6'h01}}, 6'h00}, 1'b1);
      drive(1'b1, rep(6'h01), 1'b1);
      drive(1'b0, '0, 1'b1);
      drive(1'b0, '0, 1'b1);

      // Write freezes input; next lookup sees the new entry
      drive(1'b1, rep(6'd5), 1'b1, 1'b1, 4'd2, 6'd5, 1'b1);
      drive(1'b1, rep(6'd5), 1'b1);
      drive(1'b0, '0, 1'b1);

      // Out-of-range write sets sticky error and leaves tables alone
      drive(1'b0, '0, 1'b1, 1'b1, 4'd8, 6'd5, 1'b0);
      drive(1'b1, rep(6'd5), 1'b1);
      drive(1'b1, rep(6'd0), 1'b1);
      drive(1'b0, '0, 1'b1);
      drive(1'b0, '0, 1'b1);

      // Reset while a result is stalled
      drive(1'b1, rep(6'd0), 1'b0);
      drive(1'b0, '0, 1'b0);
      rst_n = 1'b0;
      drive(1'b0, '0, 1'b0);
      rst_n = 1'b1;
      chk("rst2_out_data", bus.out_data, '0);
      drive(1'b1, {6'h3f, {6{6'h05}}, 6'h00}, 1'b1);
      drive(1'b0, '0, 1'b1);

      // Random traffic; narrow address range so programmed entries get hit
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 1) == 0) begin
            r64 = {$urandom(), $urandom()};
            d = r64[N*FI-1:0];
         end else begin
            for (int n = 0; n < N; n++) d[n*FI +: FI] = FI'($urandom_range(0, 3));
         end
         drive($urandom_range(0, 3) != 0, d, $urandom_range(0, 3) != 0,
               $urandom_range(0, 4) == 0, NW'($urandom_range(0, 9)),
               FI'($urandom_range(0, 1) == 0 ? $urandom_range(0, 3) : $urandom_range(0, DEPTH-1)),
               OW'($urandom_range(0, 1)));
      end

      for (int i = 0; i < 20 && expq.size() != 0; i++) drive(1'b0, '0, 1'b1);
      chk("drain_empty", 64'(expq.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/lut_neuron_array_prog.md
Name: lut_neuron_array_prog

Overview:
- Parametrised, runtime-programmable array of LUT neurons. Each neuron maps FAN_IN input bits to OUT_W output bits through a truth table.
- Tables are loaded through a config write port instead of being fixed at synthesis.
- Evaluation is pipelined with one registered stage and a valid/ready handshake.
- Sits between quantised activation layers in the inference datapath; upstream wiring places each neuron's FAN_IN bits contiguously.

Parameters:
- N_NEURONS, 8, number of neurons in the array.
- FAN_IN, 6, input bits per neuron (table depth is 2^FAN_IN).
- OUT_W, 1, output bits per neuron.
- NID_W, $clog2(N_NEURONS) (min 1), neuron index width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  input vector valid.
- in_ready  out  1  array accepts input this cycle.
- in_data  in  N_NEURONS*FAN_IN  neuron n uses bits [n*FAN_IN +: FAN_IN].
- out_valid  out  1  output register holds a result.
- out_ready  in  1  downstream accepts result.
- out_data  out  N_NEURONS*OUT_W  neuron n result at [n*OUT_W +: OUT_W].
- cfg_we  in  1  truth-table write strobe.
- cfg_nid  in  NID_W  target neuron.
- cfg_addr  in  FAN_IN  table entry index (input pattern).
- cfg_data  in  OUT_W  entry value.
- cfg_err  out  1  sticky: write with cfg_nid >= N_NEURONS.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset values: out_valid=0, out_data=0, cfg_err=0. All table entries clear to 0.
- Reset mid-transaction drops any held result. Tables written before reset are lost.
- Table: N_NEURONS x 2^FAN_IN x OUT_W bits, held in flip-flops (distributed).
- Write rule: when cfg_we=1 and cfg_nid<N_NEURONS, table[cfg_nid][cfg_addr] <= cfg_data at the clock edge.
  - An out-of-range cfg_nid sets cfg_err. The table is unchanged.
  - cfg_err clears only on reset.
- Config freeze: in_ready = !cfg_we && (!out_valid || out_ready).
  - A lookup never coincides with a table write.
  - A lookup accepted in cycle t+1 sees the write made in cycle t.
- Evaluation: an accept occurs when in_valid && in_ready.
  - On accept, out_data[n] <= table[n][in_data slice n] for every n, and out_valid <= 1.
  - Latency is 1 cycle, input accept to out_valid.
- Output hold: while out_valid && !out_ready, out_data and out_valid hold stable.
  - Input is stalled, because in_ready=0.
- Drain: out_valid && out_ready with no new accept sets out_valid <= 0. out_data holds its last value.
- Simultaneous drain and accept: out_data is replaced and out_valid stays 1. Throughput is one result per cycle.
- cfg_we while out_valid=1: the held result is unaffected, since it was computed from the old table. Only new lookups wait.
- Bit ordering of cfg_addr matches the input slice: cfg_addr bit 0 equals in_data[n*FAN_IN].

Optional Feature:
- Macro: LUT_READBACK_EN.
- Defined adds ports:
  - cfg_re  in  1
  - cfg_rdata  out  OUT_W
  - cfg_rvalid  out  1
- On cfg_re with cfg_we=0, cfg_rdata <= table[cfg_nid][cfg_addr] and cfg_rvalid <= 1 one cycle later.
- Otherwise cfg_rvalid <= 0.
- An out-of-range nid returns 0 and sets cfg_err.
- Reset clears both outputs. cfg_re does not stall the datapath.
- Undefined: the ports are absent and there is no readback logic.

Decomposition:
- Package lut_array_pkg holds:
  - default parameter constants;
  - the table-index helper function (nid, addr -> flat bit offset);
  - a typedef for the config write struct {nid, addr, data}.
- One sub-module, lut_neuron_prog: a single neuron's table storage, write decode and combinational lookup. It is instantiated N_NEURONS times by generate.
- The top level owns the handshake, output register, freeze logic and cfg_err.

Test Plan:
- Reset then lookup: after reset, drive in_valid=1 with all inputs 6'b101010 -> next cycle out_valid=1 and out_data=8'h00 (all-zero tables).
- Program and evaluate: write neuron 0 addr 6'b000000=1 and neuron 7 addr 6'b111111=1, then input neuron0=000000, neuron7=111111, others 000001 -> out_data=8'h81 one cycle after accept.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0 and out_data stable throughout. On release, one result per cycle with none dropped or duplicated (check 4 back-to-back vectors).
- Write/lookup ordering: cfg_we to neuron 2 addr 5 with value 1 while in_valid=1 -> in_ready=0 that cycle; the next accepted vector with slice 2=5 yields bit 2=1.
- Error flag: cfg_nid=8 with N_NEURONS=8 -> cfg_err=1 and all tables unchanged. cfg_err stays 1 until rst_n=0, and clears the cycle after reset.
- Reset mid-stall: out_valid=1 with out_ready=0, assert rst_n=0 for one cycle -> out_valid=0, tables zeroed, and a subsequent lookup returns 0.
